mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory access stage: byte-lane data memory, one-cycle-latency loads, WB pipeline register.
// Optional macro MEM_MISALIGN_TRAP_EN flags misaligned halfword/word accesses instead of aligning them down.
module mem_access_unit #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic [31:0] i_alu_result_or_addr,
    input  logic [31:0] i_write_data,
    input  logic [4:0]  i_rd,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic        i_mem_to_reg,
    input  logic        i_reg_write,
    input  logic [2:0]  i_bhw_type,
    input  logic [31:0] i_du_mem_addr,
    output logic        o_stall,
    output logic        o_wb_valid,
    output logic [31:0] o_wb_read_data,
    output logic [31:0] o_wb_alu_result,
    output logic [4:0]  o_wb_rd,
    output logic        o_wb_mem_to_reg,
    output logic        o_wb_reg_write,
    output logic        o_misaligned,
    output logic [31:0] o_du_mem_data
);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] LOAD_WAIT = 1'b1;

    logic [0:0]    state;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   rdata_q;

    logic [AW-1:0] idx;
    logic [AW-1:0] du_idx;
    logic          is_word;
    logic          is_half;
    logic          is_byte;
    logic          mis_in;
    logic [1:0]    lane_in;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic          load_accept;
    logic          unused_du_bits;

    logic [1:0]    lat_lane;
    logic [2:0]    lat_type;
    logic [4:0]    lat_rd;
    logic          lat_mem_to_reg;
    logic          lat_reg_write;
    logic          lat_mis;
    logic [31:0]   lat_addr;

    logic [7:0]    sel_b;
    logic [15:0]   sel_h;
    logic [31:0]   load_ext;

    assign idx            = i_alu_result_or_addr[AW+1:2];
    assign du_idx         = i_du_mem_addr[AW+1:2];
    assign unused_du_bits = ^{i_du_mem_addr[31:AW+2], i_du_mem_addr[1:0]};

    assign is_word = (i_bhw_type == 3'b001) || (i_bhw_type == 3'b101);
    assign is_half = (i_bhw_type == 3'b010) || (i_bhw_type == 3'b111);
    assign is_byte = (i_bhw_type == 3'b100) || (i_bhw_type == 3'b110);

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_in  = (i_mem_read || i_mem_write) &&
                     ((is_half && i_alu_result_or_addr[0]) ||
                      (is_word && (i_alu_result_or_addr[1:0] != 2'b00)));
    assign lane_in = i_alu_result_or_addr[1:0];
`else
    assign mis_in  = 1'b0;
    assign lane_in = is_word ? 2'b00 :
                     is_half ? {i_alu_result_or_addr[1], 1'b0} :
                               i_alu_result_or_addr[1:0];
`endif

    assign o_stall     = (state == IDLE) && i_valid && i_mem_read;
    assign load_accept = o_stall;

    // Store lane enables; a load-and-store instruction is a load, so its write is dropped.
    always_comb begin
        be    = 4'b0000;
        wdata = i_write_data;
        if (is_half) begin
            wdata = {2{i_write_data[15:0]}};
        end else if (is_byte) begin
            wdata = {4{i_write_data[7:0]}};
        end
        if ((state == IDLE) && i_valid && i_mem_write && !i_mem_read && !mis_in) begin
            if (is_word) begin
                be = 4'b1111;
            end else if (is_half) begin
                be = lane_in[1] ? 4'b1100 : 4'b0011;
            end else if (is_byte) begin
                be = 4'b0001 << lane_in;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                mem[idx][k*8 +: 8] <= wdata[k*8 +: 8];
            end
        end
        if (load_accept) begin
            rdata_q <= mem[idx];
        end
    end

    assign o_du_mem_data = mem[du_idx];

    always_comb begin
        load_ext = 32'h0;
        case (lat_lane)
            2'd0:    sel_b = rdata_q[7:0];
            2'd1:    sel_b = rdata_q[15:8];
            2'd2:    sel_b = rdata_q[23:16];
            default: sel_b = rdata_q[31:24];
        endcase
        sel_h = lat_lane[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (lat_type)
            3'b001, 3'b101: load_ext = rdata_q;
            3'b010:         load_ext = {{16{sel_h[15]}}, sel_h};
            3'b111:         load_ext = {16'h0, sel_h};
            3'b100:         load_ext = {{24{sel_b[7]}}, sel_b};
            3'b110:         load_ext = {24'h0, sel_b};
            default:        load_ext = 32'h0;
        endcase
        if (lat_mis) begin
            load_ext = 32'h0;
        end
    end

    // Loads retire from the latched copy in LOAD_WAIT; everything else retires straight from IDLE.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state           <= IDLE;
            o_wb_valid      <= 1'b0;
            o_wb_read_data  <= 32'h0;
            o_wb_alu_result <= 32'h0;
            o_wb_rd         <= 5'h0;
            o_wb_mem_to_reg <= 1'b0;
            o_wb_reg_write  <= 1'b0;
            o_misaligned    <= 1'b0;
            lat_lane        <= 2'b00;
            lat_type        <= 3'b000;
            lat_rd          <= 5'h0;
            lat_mem_to_reg  <= 1'b0;
            lat_reg_write   <= 1'b0;
            lat_mis         <= 1'b0;
            lat_addr        <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && i_mem_read) begin
                        state          <= LOAD_WAIT;
                        lat_lane       <= lane_in;
                        lat_type       <= i_bhw_type;
                        lat_rd         <= i_rd;
                        lat_mem_to_reg <= i_mem_to_reg;
                        lat_reg_write  <= i_reg_write;
                        lat_mis        <= mis_in;
                        lat_addr       <= i_alu_result_or_addr;
                        o_wb_valid     <= 1'b0;
                        o_wb_reg_write <= 1'b0;
                        o_misaligned   <= 1'b0;
                    end else if (i_valid) begin
                        o_wb_valid      <= 1'b1;
                        o_wb_read_data  <= 32'h0;
                        o_wb_alu_result <= i_alu_result_or_addr;
                        o_wb_rd         <= i_rd;
                        o_wb_mem_to_reg <= i_mem_to_reg;
                        o_wb_reg_write  <= i_reg_write;
                        o_misaligned    <= mis_in;
                    end else begin
                        o_wb_valid     <= 1'b0;
                        o_wb_reg_write <= 1'b0;
                        o_misaligned   <= 1'b0;
                    end
                end
                LOAD_WAIT: begin
                    state           <= IDLE;
                    o_wb_valid      <= 1'b1;
                    o_wb_read_data  <= load_ext;
                    o_wb_alu_result <= lat_addr;
                    o_wb_rd         <= lat_rd;
                    o_wb_mem_to_reg <= lat_mem_to_reg;
                    o_wb_reg_write  <= lat_reg_write && !lat_mis;
                    o_misaligned    <= lat_mis;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-array reference model, randomized and directed traffic.
module tb_mem_access_unit;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [31:0] i_addr;
    logic [31:0] i_write_data;
    logic [4:0]  i_rd;
    logic        i_mem_read;
    logic        i_mem_write;
    logic        i_mem_to_reg;
    logic        i_reg_write;
    logic [2:0]  i_bhw_type;
    logic [31:0] i_du_mem_addr;
    logic        o_stall;
    logic        o_wb_valid;
    logic [31:0] o_wb_read_data;
    logic [31:0] o_wb_alu_result;
    logic [4:0]  o_wb_rd;
    logic        o_wb_mem_to_reg;
    logic        o_wb_reg_write;
    logic        o_misaligned;
    logic [31:0] o_du_mem_data;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        m2r;
        logic        rw;
        logic        mis;
    } exp_t;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [7:0] mdl [DEPTH*4];

    mem_access_unit #(.DEPTH(DEPTH)) dut (
        .i_clk                (clk),
        .i_reset              (rst),
        .i_valid              (i_valid),
        .i_alu_result_or_addr (i_addr),
        .i_write_data         (i_write_data),
        .i_rd                 (i_rd),
        .i_mem_read           (i_mem_read),
        .i_mem_write          (i_mem_write),
        .i_mem_to_reg         (i_mem_to_reg),
        .i_reg_write          (i_reg_write),
        .i_bhw_type           (i_bhw_type),
        .i_du_mem_addr        (i_du_mem_addr),
        .o_stall              (o_stall),
        .o_wb_valid           (o_wb_valid),
        .o_wb_read_data       (o_wb_read_data),
        .o_wb_alu_result      (o_wb_alu_result),
        .o_wb_rd              (o_wb_rd),
        .o_wb_mem_to_reg      (o_wb_mem_to_reg),
        .o_wb_reg_write       (o_wb_reg_write),
        .o_misaligned         (o_misaligned),
        .o_du_mem_data        (o_du_mem_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mdl_word(input logic [31:0] a);
        int base;
        base = int'((a >> 2) % DEPTH) * 4;
        return {mdl[base+3], mdl[base+2], mdl[base+1], mdl[base]};
    endfunction

    // Reference: byte-addressed memory, size/extension decoded straight from the type code.
    task automatic model_issue(input logic rd_f, input logic wr_f, input logic [2:0] bhw,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [4:0] rd, input logic m2r, input logic rw,
                               output exp_t e);
        int          base;
        int          size;
        int          off;
        logic        sgn;
        logic        mis;
        logic [31:0] v;
        base = int'((a >> 2) % DEPTH) * 4;
        case (bhw)
            3'b001, 3'b101: size = 4;
            3'b010, 3'b111: size = 2;
            3'b100, 3'b110: size = 1;
            default:        size = 0;
        endcase
        sgn = (bhw == 3'b001) || (bhw == 3'b010) || (bhw == 3'b100);
        off = int'(a[1:0]);
        mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis = (rd_f || wr_f) && ((size == 2 && (off % 2) != 0) || (size == 4 && off != 0));
`else
        if (size == 4) off = 0;
        if (size == 2) off = off - (off % 2);
`endif
        v = 32'h0;
        if (rd_f) begin
            if (!mis && size != 0) begin
                for (int b = 0; b < size; b++) v[8*b +: 8] = mdl[base + off + b];
                if (sgn && size == 2) v = {{16{v[15]}}, v[15:0]};
                if (sgn && size == 1) v = {{24{v[7]}}, v[7:0]};
            end
        end else if (wr_f && !mis && size != 0) begin
            for (int b = 0; b < size; b++) mdl[base + off + b] = wd[8*b +: 8];
        end
        e.cyc   = cyc + (rd_f ? 2 : 1);
        e.rdata = v;
        e.alu   = a;
        e.rd    = rd;
        e.m2r   = m2r;
        e.rw    = rw && !(rd_f && mis);
        e.mis   = mis;
    endtask

    task automatic apply_stimulus(input logic rd_f, input logic wr_f, input logic [2:0] bhw,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [4:0] rd, input logic m2r, input logic rw);
        exp_t e;
        @(negedge clk);
        i_valid      = 1'b1;
        i_mem_read   = rd_f;
        i_mem_write  = wr_f;
        i_bhw_type   = bhw;
        i_addr       = a;
        i_write_data = wd;
        i_rd         = rd;
        i_mem_to_reg = m2r;
        i_reg_write  = rw;
        model_issue(rd_f, wr_f, bhw, a, wd, rd, m2r, rw, e);
        exp_q.push_back(e);
        #1 check_output("stall_issue", {31'h0, o_stall}, {31'h0, rd_f});
        @(posedge clk);
        if (rd_f) begin
            // Scramble the inputs during LOAD_WAIT: the unit must ignore them.
            @(negedge clk);
            i_valid      = 1'($urandom);
            i_mem_read   = 1'($urandom);
            i_mem_write  = 1'($urandom);
            i_bhw_type   = 3'($urandom);
            i_addr       = $urandom;
            i_write_data = $urandom;
            i_rd         = 5'($urandom);
            i_mem_to_reg = 1'($urandom);
            i_reg_write  = 1'($urandom);
            #1 check_output("stall_load_wait", {31'h0, o_stall}, 32'h0);
            @(posedge clk);
        end
    endtask

    task automatic bubble();
        @(negedge clk);
        i_valid       = 1'b0;
        i_mem_read    = 1'($urandom);
        i_mem_write   = 1'($urandom);
        i_addr        = $urandom;
        i_write_data  = $urandom;
        i_du_mem_addr = $urandom;
        #1 check_output("du_read", o_du_mem_data, mdl_word(i_du_mem_addr));
        @(posedge clk);
    endtask

    task automatic du_check(input string name, input logic [31:0] a, input logic [31:0] req);
        i_du_mem_addr = a;
        #1 check_output(name, o_du_mem_data, req);
    endtask

    // Monitor: every WB pulse must match the oldest expected entry, including its cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_wb_valid) begin
                if (exp_q.size() == 0) begin
                    check_output("wb_unexpected", {31'h0, o_wb_valid}, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_output("wb_cycle",     cyc, e.cyc);
                    check_output("wb_read_data", o_wb_read_data, e.rdata);
                    check_output("wb_alu",       o_wb_alu_result, e.alu);
                    check_output("wb_rd",        {27'h0, o_wb_rd}, {27'h0, e.rd});
                    check_output("wb_mem_to_reg", {31'h0, o_wb_mem_to_reg}, {31'h0, e.m2r});
                    check_output("wb_reg_write", {31'h0, o_wb_reg_write}, {31'h0, e.rw});
                    check_output("wb_misaligned", {31'h0, o_misaligned}, {31'h0, e.mis});
                end
            end else begin
                check_output("bubble_reg_write", {31'h0, o_wb_reg_write}, 32'h0);
                check_output("bubble_misaligned", {31'h0, o_misaligned}, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] ra;
        int          op;
        rst           = 1'b1;
        i_valid       = 1'b0;
        i_addr        = 32'h0;
        i_write_data  = 32'h0;
        i_rd          = 5'h0;
        i_mem_read    = 1'b0;
        i_mem_write   = 1'b0;
        i_mem_to_reg  = 1'b0;
        i_reg_write   = 1'b0;
        i_bhw_type    = 3'b000;
        i_du_mem_addr = 32'h0;
        #12;
        check_output("rst_wb_valid", {31'h0, o_wb_valid}, 32'h0);
        check_output("rst_read_data", o_wb_read_data, 32'h0);
        check_output("rst_alu", o_wb_alu_result, 32'h0);
        check_output("rst_rd_ctl", {25'h0, o_wb_rd, o_wb_mem_to_reg, o_wb_reg_write, o_misaligned}, 32'h0);
        check_output("rst_stall", {31'h0, o_stall}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b0, 1'b1, 3'b001, i * 4, $urandom, 5'h0, 1'b0, 1'b0);

        apply_stimulus(1'b0, 1'b1, 3'b001, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'b001, 32'h10, 32'h0, 5'd1, 1'b1, 1'b1);
        bubble();

        apply_stimulus(1'b0, 1'b1, 3'b001, 32'h10, 32'h12345678, 5'd0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 3'b100, 32'h11, 32'h000000AA, 5'd0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'b110, 32'h11, 32'h0, 5'd2, 1'b1, 1'b1);
        apply_stimulus(1'b1, 1'b0, 3'b001, 32'h10, 32'h0, 5'd3, 1'b1, 1'b1);
        du_check("du_sb_merge", 32'h10, 32'h1234AA78);

        apply_stimulus(1'b0, 1'b1, 3'b001, 32'h20, 32'h80F0007F, 5'd0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'b010, 32'h22, 32'h0, 5'd4, 1'b1, 1'b1);
        apply_stimulus(1'b1, 1'b0, 3'b111, 32'h22, 32'h0, 5'd5, 1'b1, 1'b1);
        apply_stimulus(1'b1, 1'b0, 3'b100, 32'h20, 32'h0, 5'd6, 1'b1, 1'b1);
        du_check("du_word20", 32'h20, 32'h80F0007F);

        apply_stimulus(1'b1, 1'b0, 3'b001, 32'h13, 32'h0, 5'd7, 1'b1, 1'b1);
        apply_stimulus(1'b1, 1'b1, 3'b001, 32'h20, 32'h11111111, 5'd8, 1'b1, 1'b1);
        du_check("du_rw_suppressed", 32'h20, 32'h80F0007F);

        apply_stimulus(1'b0, 1'b1, 3'b001, DEPTH * 4 + 8, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0);
        du_check("du_wrap", 32'h8, 32'hCAFEF00D);
        apply_stimulus(1'b1, 1'b0, 3'b001, 32'h8, 32'h0, 5'd10, 1'b1, 1'b1);

        // Reset in the middle of LOAD_WAIT: pending load vanishes, memory survives.
        apply_stimulus(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd9, 1'b1, 1'b1);
        @(negedge clk);
        i_valid    = 1'b1;
        i_mem_read = 1'b1;
        i_mem_write = 1'b0;
        i_bhw_type = 3'b001;
        i_addr     = 32'h10;
        i_rd       = 5'd11;
        #1 check_output("stall_pre_reset", {31'h0, o_stall}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        rst     = 1'b1;
        exp_q.delete();
        #1;
        check_output("midrst_wb_valid", {31'h0, o_wb_valid}, 32'h0);
        check_output("midrst_read_data", o_wb_read_data, 32'h0);
        check_output("midrst_alu", o_wb_alu_result, 32'h0);
        check_output("midrst_rd_ctl", {25'h0, o_wb_rd, o_wb_mem_to_reg, o_wb_reg_write, o_misaligned}, 32'h0);
        check_output("midrst_stall", {31'h0, o_stall}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        du_check("du_after_reset", 32'h10, 32'h1234AA78);
        du_check("du_after_reset_wrap", 32'h8, 32'hCAFEF00D);
        apply_stimulus(1'b1, 1'b0, 3'b101, 32'h20, 32'h0, 5'd12, 1'b1, 1'b1);

        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            ra = ($urandom_range(0, 1) == 0) ? $urandom : (32'h10 + $urandom_range(0, 47));
            case (op)
                0, 1:    bubble();
                2, 3, 4: apply_stimulus(1'b1, 1'b0, 3'($urandom), ra, $urandom, 5'($urandom),
                                        1'($urandom), 1'($urandom));
                5, 6, 7: apply_stimulus(1'b0, 1'b1, 3'($urandom), ra, $urandom, 5'($urandom),
                                        1'($urandom), 1'($urandom));
                8:       apply_stimulus(1'b0, 1'b0, 3'($urandom), ra, $urandom, 5'($urandom),
                                        1'($urandom), 1'($urandom));
                default: apply_stimulus(1'b1, 1'b1, 3'($urandom), ra, $urandom, 5'($urandom),
                                        1'($urandom), 1'($urandom));
            endcase
        end

        @(negedge clk);
        i_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_output("queue_drain", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
